// File: rtl/button_conditioner.sv
// Three-button conditioner: synchronize, debounce, press/held outputs.
// Left/right buttons auto-repeat while held; go fires once per press.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 15000000
) (
  input  logic CLK100MHZ,
  input  logic gameReset,
  input  logic pbR,
  input  logic pbL,
  input  logic pbG,
  output logic pressR,
  output logic pressL,
  output logic pressG,
  output logic heldR,
  output logic heldL,
  output logic heldG
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] R_ONE  = RW'(1);
  localparam logic [RW-1:0] R_DLY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PER  = RW'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM_PRESS,
    HELD,
    CONFIRM_RELEASE
  } state_e;

  logic [2:0] pb_w;
  logic [2:0] held_w;
  logic [2:0] ev_w;
  logic [2:0] press_q;

  assign pb_w = {pbG, pbL, pbR};

  // Index 0 = right, 1 = left, 2 = go.
  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic          sync1_q;
    logic          sync2_q;
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          held_q;
    logic          active;
    logic          rep_hit;

    assign active = (state_q == HELD) ||
                    (state_q == CONFIRM_RELEASE);

    always_ff @(posedge CLK100MHZ or negedge gameReset) begin
      if (!gameReset) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= pb_w[b];
        sync2_q <= sync1_q;
      end
    end

    always_ff @(posedge CLK100MHZ or negedge gameReset) begin
      if (!gameReset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        held_q  <= 1'b0;
      end else begin
        held_q <= active;
        unique case (state_q)
          IDLE: begin
            if (!sync2_q) begin
              state_q <= CONFIRM_PRESS;
              cnt_q   <= C_ONE;
            end
          end
          CONFIRM_PRESS: begin
            if (sync2_q) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q >= C_LAST) begin
              state_q <= HELD;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + C_ONE;
            end
          end
          HELD: begin
            if (sync2_q) begin
              state_q <= CONFIRM_RELEASE;
              cnt_q   <= C_ONE;
            end
          end
          CONFIRM_RELEASE: begin
            if (!sync2_q) begin
              state_q <= HELD;
              cnt_q   <= '0;
            end else if (cnt_q >= C_LAST) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + C_ONE;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    if (b < 2) begin : g_rep
      logic [RW-1:0] rc_q;
      logic          first_q;

      // rc_q counts held cycles since the last pulse; bounded by target.
      assign rep_hit = active && held_q &&
                       (rc_q == (first_q ? R_DLY : R_PER));

      always_ff @(posedge CLK100MHZ or negedge gameReset) begin
        if (!gameReset) begin
          rc_q    <= '0;
          first_q <= 1'b1;
        end else if (!active) begin
          rc_q    <= '0;
          first_q <= 1'b1;
        end else if (rep_hit) begin
          rc_q    <= R_ONE;
          first_q <= 1'b0;
        end else if (rc_q != '1) begin
          rc_q <= rc_q + R_ONE;
        end
      end
    end else begin : g_norep
      assign rep_hit = 1'b0;
    end

    assign held_w[b] = held_q;
    assign ev_w[b]   = active && (!held_q || rep_hit);
  end

  // Simultaneous left/right events cancel each other.
  always_ff @(posedge CLK100MHZ or negedge gameReset) begin
    if (!gameReset) begin
      press_q <= '0;
    end else begin
      press_q[0] <= ev_w[0] && !ev_w[1];
      press_q[1] <= ev_w[1] && !ev_w[0];
      press_q[2] <= ev_w[2];
    end
  end

  assign pressR = press_q[0];
  assign pressL = press_q[1];
  assign pressG = press_q[2];
  assign heldR  = held_w[0];
  assign heldL  = held_w[1];
  assign heldG  = held_w[2];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random
// stimulus checked each cycle against a behavioural model.
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic pbR, pbL, pbG;
  logic pressR, pressL, pressG;
  logic heldR, heldL, heldG;

  int tests = 0;
  int fails = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .CLK100MHZ(clk),
    .gameReset(rst_n),
    .pbR(pbR),
    .pbL(pbL),
    .pbG(pbG),
    .pressR(pressR),
    .pressL(pressL),
    .pressG(pressG),
    .heldR(heldR),
    .heldL(heldL),
    .heldG(heldG)
  );

  always #5 clk = ~clk;

  // Model: accepted level flips after D consecutive opposite samples of
  // the pin as it was two edges earlier; outputs show the level one edge
  // later; repeats fall at RD, RD+RP, ... cycles after the initial press.
  bit m_lvl[3];
  bit m_hp[3];
  bit m_p1[3];
  bit m_p2[3];
  int m_run[3];
  int m_tp[3];
  logic [5:0] m_exp;
  int ecount = 0;
  int cntP[3];
  int lastP[3];
  int qR[$];

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_lvl[b] = 0; m_hp[b] = 0;
      m_p1[b] = 1; m_p2[b] = 1;
      m_run[b] = 0; m_tp[b] = 0;
    end
    m_exp = '0;
  endtask

  task automatic model_step();
    bit pin[3];
    bit raw[3];
    bit hv[3];
    pin[0] = pbR; pin[1] = pbL; pin[2] = pbG;
    for (int b = 0; b < 3; b++) begin
      bit lb, first, rep, pv;
      int dt;
      lb = m_lvl[b];
      hv[b] = lb;
      first = lb && !m_hp[b];
      if (first) m_tp[b] = ecount;
      dt = ecount - m_tp[b];
      rep = lb && !first && (b < 2) &&
            (dt == RD || (dt > RD && (dt - RD) % RP == 0));
      raw[b] = first || rep;
      m_hp[b] = lb;
      pv = !m_p2[b];
      if (pv != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == D) begin
          m_lvl[b] = pv;
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
      m_p2[b] = m_p1[b];
      m_p1[b] = pin[b];
    end
    m_exp = {raw[0] && !raw[1], raw[1] && !raw[0], raw[2],
             hv[0], hv[1], hv[2]};
  endtask

  initial model_reset();

  always @(posedge clk) begin
    logic [5:0] act;
    ecount++;
    if (!rst_n) model_reset();
    else model_step();
    #1;
    act = {pressR, pressL, pressG, heldR, heldL, heldG};
    tests++;
    if (act !== m_exp) begin
      fails++;
      if (fails < 20)
        $display("FAIL model cyc %0d: got %b expected %b",
                 ecount, act, m_exp);
    end
    if (pressR) begin cntP[0]++; lastP[0] = ecount; qR.push_back(ecount); end
    if (pressL) begin cntP[1]++; lastP[1] = ecount; end
    if (pressG) begin cntP[2]++; lastP[2] = ecount; end
  end

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({pressR, pressL, pressG, heldR, heldL, heldG});
  endfunction

  initial begin
    int m, r, c0, c1, c2, div;
    bit pat[10];
    int rexp[6];
    rst_n = 1'b0;
    pbR = 1'b1; pbL = 1'b1; pbG = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Sub-cycle glitch on go
    @(posedge clk);
    c0 = cntP[2];
    #2 pbG = 1'b0;
    #5 pbG = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_pressG", cntP[2] - c0, 0);
    chk("glitch_heldG", int'(heldG), 0);

    // Clean 100 ns go press
    @(negedge clk);
    c0 = cntP[2];
    pbG = 1'b0;
    m = ecount + 1;
    repeat (10) @(negedge clk);
    chk("g_press_count", cntP[2] - c0, 1);
    chk("g_press_latency", lastP[2] - m, 6);
    chk("g_held", int'(heldG), 1);
    pbG = 1'b1;
    r = ecount + 1;
    for (int i = 0; i < 20 && heldG; i++) @(negedge clk);
    chk("g_held_released", int'(heldG), 0);
    chk("g_release_latency", ecount - r, 6);
    repeat (4) @(negedge clk);

    // Bouncing left press
    pat = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
    c1 = cntP[1];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pbL = pat[i];
      if (i == 8) m = ecount + 1;
    end
    repeat (10) @(negedge clk);
    chk("l_bounce_count", cntP[1] - c1, 1);
    chk("l_bounce_latency", lastP[1] - m, 6);
    pbL = 1'b1;
    repeat (12) @(negedge clk);

    // Right held 60 cycles: auto-repeat
    rexp = '{6, 26, 34, 42, 50, 58};
    qR.delete();
    @(negedge clk);
    pbR = 1'b0;
    m = ecount + 1;
    repeat (60) @(negedge clk);
    pbR = 1'b1;
    repeat (15) @(negedge clk);
    chk("r_repeat_count", qR.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < qR.size()) chk("r_repeat_offset", qR[i] - m, rexp[i]);
    chk("r_held_after", int'(heldR), 0);

    // Simultaneous left/right (and go)
    @(negedge clk);
    c0 = cntP[0]; c1 = cntP[1]; c2 = cntP[2];
    pbL = 1'b0; pbR = 1'b0; pbG = 1'b0;
    repeat (30) @(negedge clk);
    chk("lr_pressR", cntP[0] - c0, 0);
    chk("lr_pressL", cntP[1] - c1, 0);
    chk("lr_pressG", cntP[2] - c2, 1);
    chk("lr_heldL", int'(heldL), 1);
    chk("lr_heldR", int'(heldR), 1);
    pbL = 1'b1; pbR = 1'b1; pbG = 1'b1;
    repeat (12) @(negedge clk);

    // Reset while held, then release with button still down
    pbR = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_heldR_before", int'(heldR), 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outputs", outs(), 0);
    @(negedge clk);
    chk("rst_hold_outputs", outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    c0 = cntP[0];
    m = ecount + 1;
    repeat (10) @(negedge clk);
    chk("rst_fresh_count", cntP[0] - c0, 1);
    chk("rst_fresh_latency", lastP[0] - m, 6);
    pbR = 1'b1;
    repeat (10) @(negedge clk);

    // Random stimulus
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      div = ((c / 500) % 2 == 1) ? 40 : 6;
      if ($urandom_range(0, div - 1) == 0) pbR = ~pbR;
      if ($urandom_range(0, div - 1) == 0) pbL = ~pbL;
      if ($urandom_range(0, div - 1) == 0) pbG = ~pbG;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
